// File: rtl/divider_reconstruct_seq_if.sv
// divider_reconstruct_seq_if
//   Transaction bus between a divider under test, the reconstruction block
//   and the consumer of the reconstructed dividend.
//   Request side : in_valid/in_ready handshake carrying q, d, r, n_ref.
//   Result side  : out_valid/out_ready handshake carrying n_out, err.
//   Modports:
//     master - the environment (drives requests, accepts results)
//     slave  - divider_reconstruct_seq
interface divider_reconstruct_seq_if #(
  parameter int W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      q;
  logic [W-1:0]      d;
  logic [W-1:0]      r;
  logic [2*W-1:0]    n_ref;

  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    n_out;
  logic [2*W:0]      err;

  modport master (
    output in_valid, q, d, r, n_ref, out_ready,
    input  in_ready, out_valid, n_out, err
  );

  modport slave (
    input  in_valid, q, d, r, n_ref, out_ready,
    output in_ready, out_valid, n_out, err
  );

endinterface

// File: rtl/divider_reconstruct_seq.sv
// divider_reconstruct_seq
//   Rebuilds the dividend n' = q*d + r from a divider's quotient/remainder by
//   a sequential LSB-first shift-add over W cycles, then reports the signed
//   error n' - n_ref and accumulates squared-error / sample-count statistics
//   (saturating) so the accuracy of an approximate divider can be measured
//   in hardware. One transaction in flight at a time.
//
//   Ports
//     clk          clock, all state on the rising edge
//     rst          synchronous active-high reset (aborts any transaction)
//     bus          slave side of divider_reconstruct_seq_if
//                    in_valid/in_ready, q, d, r, n_ref  (request)
//                    out_valid/out_ready, n_out, err    (result)
//     clear_stats  zero sse and sample_cnt at the next edge
//     sse          saturating sum of err^2 over completed samples
//     sample_cnt   saturating count of completed samples
module divider_reconstruct_seq #(
  parameter int W     = 8,
  parameter int ACC_W = 48,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  divider_reconstruct_seq_if.slave bus,
  input  logic                 clear_stats,
  output logic [ACC_W-1:0]     sse,
  output logic [CNT_W-1:0]     sample_cnt
);

  localparam int NW    = 2 * W;
  localparam int SQ_W  = 4 * W + 2;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [W-1:0]      q_reg;
  logic [NW-1:0]     d_ext;
  logic [NW-1:0]     n_ref_reg;
  logic [NW-1:0]     acc;
  logic [IDX_W-1:0]  bit_idx;

  logic              out_valid_reg;
  logic [NW-1:0]     n_out_reg;
  logic [NW:0]       err_reg;

  logic              accept;
  logic              last_bit;
  logic              handshake;

  logic [SQ_W-1:0]   err_sext;
  logic [SQ_W-1:0]   err_sq;

  logic [ACC_W-1:0]  sse_base;
  logic [ACC_W:0]    sse_sum;
  logic [ACC_W-1:0]  sse_next;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_next;

  // in_ready is forced low while reset is asserted, not just after it.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.n_out     = n_out_reg;
  assign bus.err       = err_reg;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_bit  = (bit_idx == IDX_W'(W - 1));
  assign handshake = out_valid_reg && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE is left only on a real handshake, which needs the
  // registered out_valid, so the first DONE cycle never completes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)    state_next = MUL;
      MUL:  if (last_bit)  state_next = DONE;
      DONE: if (handshake) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Shift-add datapath and result registers.
  // The first DONE cycle registers n_out and the 2W+1-bit error, which is
  // why out_valid appears W+1 edges after the accepting edge. Operands are
  // unsigned, so zero-extending both before the subtract yields the signed
  // difference directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg         <= '0;
      d_ext         <= '0;
      n_ref_reg     <= '0;
      acc           <= '0;
      bit_idx       <= '0;
      out_valid_reg <= 1'b0;
      n_out_reg     <= '0;
      err_reg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_reg     <= bus.q;
            d_ext     <= {{W{1'b0}}, bus.d};
            n_ref_reg <= bus.n_ref;
            acc       <= {{W{1'b0}}, bus.r};
            bit_idx   <= '0;
          end
        end
        MUL: begin
          if (q_reg[bit_idx]) begin
            acc <= acc + (d_ext << bit_idx);
          end
          bit_idx <= bit_idx + 1'b1;
        end
        DONE: begin
          if (!out_valid_reg) begin
            n_out_reg     <= acc;
            err_reg       <= {1'b0, acc} - {1'b0, n_ref_reg};
            out_valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Square of the signed error. Sign-extending to the full product width
  // lets a same-width multiply give the exact (always non-negative) square.
  assign err_sext = {{(SQ_W - NW - 1){err_reg[NW]}}, err_reg};
  assign err_sq   = err_sext * err_sext;

  // Statistics update. A coincident clear zeroes the base first so that
  // the sample completing in the same cycle is still counted.
  always_comb begin
    sse_base = clear_stats ? '0 : sse;
    cnt_base = clear_stats ? '0 : sample_cnt;
    sse_sum  = {1'b0, sse_base};
    sse_next = sse_base;
    cnt_next = cnt_base;
    if (handshake) begin
      sse_sum  = {1'b0, sse_base} + {{(ACC_W + 1 - SQ_W){1'b0}}, err_sq};
      sse_next = sse_sum[ACC_W] ? '1 : sse_sum[ACC_W-1:0];
      cnt_next = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sse        <= '0;
      sample_cnt <= '0;
    end else begin
      sse        <= sse_next;
      sample_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_divider_reconstruct_seq.sv
// tb_divider_reconstruct_seq
//   Self-checking bench for divider_reconstruct_seq: a table of directed
//   vectors with hand-computed n_out/err/err^2, a small saturating model of
//   the statistics, and hand-written sequences for back-pressure, reset
//   mid-transaction, clear/handshake coincidence and sse saturation.
//   ACC_W is set to its minimum (4W+2 = 34) so saturation is reachable.
module tb_divider_reconstruct_seq;

  localparam int W     = 8;
  localparam int ACC_W = 34;
  localparam int CNT_W = 32;
  localparam logic [63:0] SSE_MAX = (64'd1 << ACC_W) - 64'd1;

  typedef struct {
    string        name;
    logic [7:0]   q;
    logic [7:0]   d;
    logic [7:0]   r;
    logic [15:0]  n_ref;
    logic [15:0]  n_out;
    logic [16:0]  err;
    logic [63:0]  sq;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear_stats;
  logic [ACC_W-1:0]  sse;
  logic [CNT_W-1:0]  sample_cnt;

  int                errors = 0;
  int                checks = 0;
  logic [63:0]       exp_sse;
  logic [31:0]       exp_cnt;
  vec_t              vecs [8];

  divider_reconstruct_seq_if #(.W(W)) bus ();

  divider_reconstruct_seq #(
    .W     (W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .clear_stats (clear_stats),
    .sse         (sse),
    .sample_cnt  (sample_cnt)
  );

  always #5 clk = ~clk;

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    s = a + b;
    return (s > SSE_MAX) ? SSE_MAX : s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a request and return right after the accepting edge.
  task automatic applyStimulus(input vec_t v, input bit hold_valid);
    int guard;
    @(negedge clk);
    bus.q        = v.q;
    bus.d        = v.d;
    bus.r        = v.r;
    bus.n_ref    = v.n_ref;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({v.name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    if (!hold_valid) bus.in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid is seen.
  task automatic waitResult(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.out_valid && cycles < 40);
  endtask

  // Full transaction with out_ready high; optional clear in the handshake cycle.
  task automatic runVector(input vec_t v, input bit clear_at_hs);
    int cycles;
    applyStimulus(v, 1'b0);
    waitResult(cycles);
    checkOutput({v.name, " latency"}, 64'(cycles), 64'd9);
    checkOutput({v.name, " n_out"}, 64'(bus.n_out), 64'(v.n_out));
    checkOutput({v.name, " err"}, 64'(bus.err), 64'(v.err));
    if (clear_at_hs) begin
      clear_stats = 1'b1;
      exp_sse = '0;
      exp_cnt = '0;
    end
    exp_sse = sat_add(exp_sse, v.sq);
    exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    checkOutput({v.name, " out_valid_fall"}, 64'(bus.out_valid), 64'd0);
    checkOutput({v.name, " sse"}, 64'(sse), exp_sse);
    checkOutput({v.name, " sample_cnt"}, 64'(sample_cnt), 64'(exp_cnt));
    checkOutput({v.name, " in_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    vec_t stall_v;
    vec_t other_v;
    int   cycles;

    //               name   q       d       r       n_ref       n_out       err          sq
    vecs[0] = '{"t1",       8'd42,  8'd7,   8'd3,   16'd297,    16'd297,    17'd0,       64'd0};
    vecs[1] = '{"t2",       8'd255, 8'd255, 8'd255, 16'd0,      16'd65280,  17'd65280,   64'd4261478400};
    vecs[2] = '{"t3",       8'd42,  8'd7,   8'd3,   16'd300,    16'd297,    17'h1FFFD,   64'd9};
    vecs[3] = '{"zero",     8'd0,   8'd0,   8'd0,   16'd0,      16'd0,      17'd0,       64'd0};
    vecs[4] = '{"q_zero",   8'd0,   8'd200, 8'd17,  16'd17,     16'd17,     17'd0,       64'd0};
    vecs[5] = '{"neg_small",8'd1,   8'd1,   8'd0,   16'd5,      16'd1,      17'h1FFFC,   64'd16};
    vecs[6] = '{"neg_big",  8'd255, 8'd1,   8'd0,   16'd65535,  16'd255,    17'h10100,   64'd4261478400};
    vecs[7] = '{"mixed",    8'd128, 8'd2,   8'd1,   16'd200,    16'd257,    17'd57,      64'd3249};

    rst          = 1'b1;
    clear_stats  = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.q        = '0;
    bus.d        = '0;
    bus.r        = '0;
    bus.n_ref    = '0;
    exp_sse      = '0;
    exp_cnt      = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset n_out", 64'(bus.n_out), 64'd0);
    checkOutput("reset err", 64'(bus.err), 64'd0);
    checkOutput("reset sse", 64'(sse), 64'd0);
    checkOutput("reset sample_cnt", 64'(sample_cnt), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      runVector(vecs[i], 1'b0);
    end

    // Back-pressure: out_ready low for 5 DONE cycles with in_valid held high.
    stall_v = '{"stall", 8'd10, 8'd20, 8'd5, 16'd200, 16'd205, 17'd5, 64'd25};
    bus.out_ready = 1'b0;
    applyStimulus(stall_v, 1'b1);
    bus.q     = 8'd99;
    bus.d     = 8'd99;
    bus.r     = 8'd99;
    bus.n_ref = 16'd1;
    waitResult(cycles);
    checkOutput("stall latency", 64'(cycles), 64'd9);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stall out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall n_out", 64'(bus.n_out), 64'(stall_v.n_out));
      checkOutput("stall err", 64'(bus.err), 64'(stall_v.err));
      checkOutput("stall in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("stall hs in_ready", 64'(bus.in_ready), 64'd0);
    exp_sse = sat_add(exp_sse, stall_v.sq);
    exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("stall out_valid_fall", 64'(bus.out_valid), 64'd0);
    checkOutput("stall sse", 64'(sse), exp_sse);
    checkOutput("stall sample_cnt", 64'(sample_cnt), 64'(exp_cnt));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall no extra txn", 64'(bus.out_valid), 64'd0);
    checkOutput("stall cnt held", 64'(sample_cnt), 64'(exp_cnt));

    // Reset pulsed in the 4th MUL cycle aborts the transaction.
    applyStimulus(vecs[0], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid-reset in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sse = '0;
    exp_cnt = '0;
    #1;
    checkOutput("abort out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("abort sse", 64'(sse), 64'd0);
    checkOutput("abort sample_cnt", 64'(sample_cnt), 64'd0);
    runVector(vecs[0], 1'b0);

    // clear_stats coincident with the handshake of test 3, then clear alone.
    runVector(vecs[2], 1'b1);
    checkOutput("clear+hs sse", 64'(sse), 64'd9);
    checkOutput("clear+hs sample_cnt", 64'(sample_cnt), 64'd1);
    @(negedge clk);
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    exp_sse = '0;
    exp_cnt = '0;
    checkOutput("clear sse", 64'(sse), 64'd0);
    checkOutput("clear sample_cnt", 64'(sample_cnt), 64'd0);
    checkOutput("clear keeps n_out", 64'(bus.n_out), 64'd297);

    // sse saturation: five maximal squares overflow a 34-bit accumulator.
    for (int k = 0; k < 5; k++) begin
      runVector(vecs[1], 1'b0);
    end
    checkOutput("sat sse all-ones", 64'(sse), SSE_MAX);
    checkOutput("sat sample_cnt", 64'(sample_cnt), 64'd5);

    // One more sample after saturation must not wrap.
    other_v = vecs[7];
    runVector(other_v, 1'b0);
    checkOutput("sat sse held", 64'(sse), SSE_MAX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
